// File: rtl/reg_write_seq_pkg.sv
// Shared types and header field positions for the register write sequencer.
// Header layout: [AW-1:0] start address, [2*AW-1:AW] length minus one.
package reg_write_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int ADDR_LSB = 0;

    function automatic int addr_msb(input int aw);
        return aw - 1;
    endfunction

    function automatic int len_lsb(input int aw);
        return aw;
    endfunction

    function automatic int len_msb(input int aw);
        return 2 * aw - 1;
    endfunction

endpackage

// File: rtl/reg_write_seq_if.sv
// Upstream beat stream: valid/ready handshake with a WIDTH-bit payload.
interface reg_write_seq_if #(
    parameter int WIDTH = 8
);
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;

    modport master (output s_valid, s_data, input s_ready);
    modport slave  (input s_valid, s_data, output s_ready);
endinterface

// File: rtl/reg_write_seq_ptr.sv
// Modulo-NUM_REGS register pointer with load and increment controls.
module reg_ptr_wrap #(
    parameter int NUM_REGS = 16,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (load) begin
            ptr_reg <= load_val;
        end else if (inc) begin
            ptr_reg <= (ptr_reg == AW'(NUM_REGS - 1)) ? '0 : ptr_reg + AW'(1);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/reg_write_seq.sv
// Turns header+data frames into single-cycle register-file writes.
// Out-of-range start addresses swallow the frame and raise a sticky err.
module reg_write_seq
    import reg_write_seq_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int WIDTH    = 8,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_write_seq_if.slave   s,
    input  logic             err_clr,
    output logic [WIDTH-1:0] wr_data,
    output logic [AW-1:0]    wr_idx,
    output logic             wr_strobe,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    state_t           state_reg, state_next;
    logic [AW:0]      count_reg, count_next;
    logic [WIDTH-1:0] wr_data_reg;
    logic [AW-1:0]    wr_idx_reg;
    logic             wr_strobe_reg, frame_done_reg, err_reg, s_ready_reg;
    logic [AW-1:0]    ptr;
    logic             ptr_load, ptr_inc, wr_en, err_set;
    logic             accept, hdr_bad;
    logic [AW-1:0]    hdr_addr;
    logic [AW:0]      hdr_len;

    assign accept   = s.s_valid && s_ready_reg;
    assign hdr_addr = s.s_data[addr_msb(AW):ADDR_LSB];
    assign hdr_len  = {1'b0, s.s_data[len_msb(AW):len_lsb(AW)]} + (AW+1)'(1);
    assign hdr_bad  = {1'b0, hdr_addr} >= (AW+1)'(NUM_REGS);

    reg_ptr_wrap #(.NUM_REGS(NUM_REGS), .AW(AW)) u_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ptr_load),
        .load_val (hdr_addr),
        .inc      (ptr_inc),
        .ptr      (ptr)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        ptr_load   = 1'b0;
        ptr_inc    = 1'b0;
        wr_en      = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            IDLE: if (accept) begin
                count_next = hdr_len;
                if (hdr_bad) begin
                    state_next = DROP;
                    err_set    = 1'b1;
                end else begin
                    state_next = DATA;
                    ptr_load   = 1'b1;
                end
            end
            DATA: if (accept) begin
                wr_en      = 1'b1;
                ptr_inc    = 1'b1;
                count_next = count_reg - (AW+1)'(1);
                if (count_reg == (AW+1)'(1)) state_next = DONE;
            end
            DROP: if (accept) begin
                count_next = count_reg - (AW+1)'(1);
                if (count_reg == (AW+1)'(1)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // s_ready is registered from the next state so it drops exactly for DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            wr_data_reg    <= '0;
            wr_idx_reg     <= '0;
            wr_strobe_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            err_reg        <= 1'b0;
            s_ready_reg    <= 1'b1;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            wr_strobe_reg  <= wr_en;
            frame_done_reg <= (state_next == DONE);
            s_ready_reg    <= (state_next != DONE);
            if (wr_en) begin
                wr_data_reg <= s.s_data;
                wr_idx_reg  <= ptr;
            end
            if (err_set) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign s.s_ready  = s_ready_reg;
    assign wr_data    = wr_data_reg;
    assign wr_idx     = wr_idx_reg;
    assign wr_strobe  = wr_strobe_reg;
    assign frame_done = frame_done_reg;
    assign err        = err_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: doc/reg_write_seq.md
REG_WRITE_SEQ -- requirements
Module: reg_write_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of target registers (2..256).
REQ-002 SHALL have parameter WIDTH, default 8, data width; WIDTH SHALL be >= 2*AW, where AW = $clog2(NUM_REGS).
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_valid  input  1  upstream beat valid.
REQ-006 SHALL have port s_data  input  WIDTH  upstream beat payload.
REQ-007 SHALL have port s_ready  output  1  beat accepted when s_valid && s_ready at a rising clk edge.
REQ-008 SHALL have port err_clr  input  1  clears err.
REQ-009 SHALL have port wr_data  output  WIDTH  data to the register file d input.
REQ-010 SHALL have port wr_idx  output  AW  register index to the register file en input.
REQ-011 SHALL have port wr_strobe  output  1  one-cycle pulse marking a new write.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at frame end.
REQ-014 SHALL have port err  output  1  sticky bad-address flag.

Function
REQ-015 Frame format SHALL be one header beat followed by LEN data beats; header s_data[AW-1:0] = start address, s_data[2*AW-1:AW] = LEN-1, so LEN ranges 1..2^AW.
REQ-016 The FSM SHALL have states IDLE, DATA, DROP, DONE.
REQ-017 IDLE: s_ready=1; an accepted header with address < NUM_REGS SHALL move to DATA, load the pointer with the address and the remaining count with LEN.
REQ-018 IDLE: an accepted header with address >= NUM_REGS SHALL move to DROP, load the count with LEN, and set err.
REQ-019 DATA: s_ready=1; each accepted beat SHALL, at that same edge, register wr_data=s_data and wr_idx=pointer, assert wr_strobe for the following cycle, increment the pointer, and decrement the count.
REQ-020 Pointer increment SHALL wrap from NUM_REGS-1 to 0.
REQ-021 DROP: s_ready=1; accepted beats SHALL decrement the count and SHALL NOT change wr_data, wr_idx or wr_strobe.
REQ-022 The beat that brings the count to 0 in DATA or DROP SHALL move the FSM to DONE.
REQ-023 DONE SHALL last exactly one cycle with s_ready=0 and frame_done=1, then return to IDLE.
REQ-024 s_valid low SHALL stall any state except DONE without changing state or outputs.
REQ-025 wr_data and wr_idx SHALL hold their last values between writes, so a downstream that reloads the indexed register every cycle rewrites an identical value.
REQ-026 Latency SHALL be one cycle from data-beat acceptance to the wr_data/wr_idx update; the register file captures the value one further edge later.
REQ-027 err SHALL clear on err_clr; if set and clear occur in the same cycle, set SHALL win.
REQ-028 busy SHALL be combinational from the state register.

Reset
REQ-029 Reset SHALL force state=IDLE, wr_data=0, wr_idx=0, wr_strobe=0, frame_done=0, err=0, pointer=0 and count=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; after release, the next accepted beat SHALL be treated as a header.
REQ-031 The reset outputs (index 0, data 0) SHALL match the register file's reset contents.

Structure
REQ-032 A shared package SHALL hold the state enum type and the header field-extraction constants (address LSB/MSB, length LSB/MSB) as functions of AW.
REQ-033 One sub-module SHALL be used: reg_ptr_wrap, a modulo-NUM_REGS pointer with load and increment inputs.
REQ-034 All outputs SHALL be driven directly from flops except busy.

Verification
REQ-035 Header 0x20 then beats 0xA1, 0xA2, 0xA3 with s_valid held high -> writes (idx 0, 0xA1), (1, 0xA2), (2, 0xA3) on consecutive cycles, then frame_done for one cycle with s_ready=0.
REQ-036 Header 0x1E (address 14, LEN 2) -> writes to idx 14 then idx 15; header 0x2F (address 15, LEN 3) -> writes to idx 15, 0, 1 (wrap).
REQ-037 NUM_REGS=12, header 0x1D (address 13) then 2 beats -> err=1, no wr_strobe, wr_idx/wr_data unchanged, frame_done pulses; err_clr asserted together with a new bad header -> err stays 1.
REQ-038 s_valid toggled 1/0 every cycle during a 4-beat frame -> exactly 4 writes, in order, with no duplicate wr_strobe.
REQ-039 rst_n pulsed low after the 2nd data beat of a 5-beat frame -> all outputs 0 immediately; the next beat 0x00 is taken as a header (address 0, LEN 1).
